// File: rtl/booth_mult_unit_pkg.sv
// Shared definitions for the Booth multiplier slice.
//   state_t       : FSM states (IDLE / RUN / DONE)
//   MODE_*        : values of signed_mode
//   cnt_width()   : width of a counter that must hold 0..w1
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  function automatic int cnt_width(input int w1);
    return $clog2(w1 + 1);
  endfunction

endpackage

// File: rtl/booth_mult_unit_if.sv
// Request/response bundle between the control unit (master) and the
// multiplier (slave).
//   start, signed_mode, op_a, op_b : request, sampled when the unit is idle
//   busy, done, prod_hi, prod_lo   : status and registered result
interface booth_mult_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;

  modport master (output start, signed_mode, op_a, op_b,
                  input  busy, done, prod_hi, prod_lo);
  modport slave  (input  start, signed_mode, op_a, op_b,
                  output busy, done, prod_hi, prod_lo);
endinterface

// File: rtl/booth_mult_unit_step.sv
// One radix-2 Booth step, purely combinational.
//   a, q, q_1 : current accumulator {A,Q,q_1}
//   m         : multiplicand (already extended to W1 bits)
//   a_nxt, q_nxt, q1_nxt : accumulator after add/sub and arithmetic shift
module booth_radix2_step #(parameter int W1 = 33) (
  input  logic [W1-1:0] a,
  input  logic [W1-1:0] q,
  input  logic          q_1,
  input  logic [W1-1:0] m,
  output logic [W1-1:0] a_nxt,
  output logic [W1-1:0] q_nxt,
  output logic          q1_nxt
);
  logic [W1-1:0] sum;

  always_comb begin
    sum = a;
    case ({q[0], q_1})
      2'b01:   sum = a + m;
      2'b10:   sum = a - m;
      default: sum = a;
    endcase
    // Arithmetic shift right of {sum,q,q_1}: sign of A is replicated.
    a_nxt  = {sum[W1-1], sum[W1-1:1]};
    q_nxt  = {sum[0], q[W1-1:1]};
    q1_nxt = q[0];
  end
endmodule

// File: rtl/booth_mult_unit.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation.
//   clock, reset : clock and async active-low reset
//   bus (slave)  : start/operands in; busy/done/prod_hi/prod_lo out
// Operands are extended to WIDTH+1 bits so one signed datapath serves both
// modes; WIDTH+1 steps then yield an exact 2*WIDTH-bit product.
module booth_mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  booth_mult_unit_if.slave   bus
);
  localparam int W1 = WIDTH + 1;
  localparam int CW = cnt_width(W1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [W1-1:0]   a, q, m;
  logic            q1;
  logic [W1-1:0]   a_nxt, q_nxt;
  logic            q1_nxt;
  logic [WIDTH-1:0] prod_hi, prod_lo;
  logic            done_r;
  logic            busy;
  logic            op_zero;
  logic            last;
  logic [W1-1:0]   ext_a, ext_b;
  logic            unused_top;

  assign op_zero = (bus.op_a == '0) || (bus.op_b == '0);
  assign last    = (cnt == CW'(W1 - 1));
  assign ext_a   = {bus.signed_mode & bus.op_a[WIDTH-1], bus.op_a};
  assign ext_b   = {bus.signed_mode & bus.op_b[WIDTH-1], bus.op_b};
  // Top two accumulator bits are pure sign extension of the product.
  assign unused_top = ^a[W1-1:W1-2];

  booth_radix2_step #(.W1(W1)) u_step (
    .a      (a),
    .q      (q),
    .q_1    (q1),
    .m      (m),
    .a_nxt  (a_nxt),
    .q_nxt  (q_nxt),
    .q1_nxt (q1_nxt)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = op_zero ? DONE : RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic (decoded from registered state only)
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      a       <= '0;
      q       <= '0;
      q1      <= 1'b0;
      m       <= '0;
      prod_hi <= '0;
      prod_lo <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= (state == DONE);
      case (state)
        IDLE: if (bus.start) begin
          // Zero fast path: a cleared accumulator is already the product.
          a   <= '0;
          q   <= op_zero ? '0 : ext_b;
          q1  <= 1'b0;
          m   <= ext_a;
          cnt <= '0;
        end
        RUN: begin
          a   <= a_nxt;
          q   <= q_nxt;
          q1  <= q1_nxt;
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          prod_hi <= {a[WIDTH-2:0], q[WIDTH]};
          prod_lo <= q[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done_r;
  assign bus.prod_hi = prod_hi;
  assign bus.prod_lo = prod_lo;
endmodule

// File: tb/tb_booth_mult_unit.sv
// Directed bench for booth_mult_unit: a 32-bit and an 8-bit instance,
// expected products computed by hand.
module tb_booth_mult_unit;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   k;
  int   ndone;

  booth_mult_unit_if #(.WIDTH(32)) ia ();
  booth_mult_unit_if #(.WIDTH(8))  ib ();

  booth_mult_unit #(.WIDTH(32)) u_dut32 (.clock(clk), .reset(rst_n), .bus(ia));
  booth_mult_unit #(.WIDTH(8))  u_dut8  (.clock(clk), .reset(rst_n), .bus(ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge: start is seen by the next rising edge (edge 0).
  task automatic launch32(input logic sm, input logic [31:0] a, input logic [31:0] b);
    ia.start = 1'b1; ia.signed_mode = sm; ia.op_a = a; ia.op_b = b;
    @(negedge clk);
    ia.start = 1'b0;
  endtask

  task automatic launch8(input logic sm, input logic [7:0] a, input logic [7:0] b);
    ib.start = 1'b1; ib.signed_mode = sm; ib.op_a = a; ib.op_b = b;
    @(negedge clk);
    ib.start = 1'b0;
  endtask

  // Returns number of edges after the current point until done is seen.
  task automatic wait32(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ia.done && n < 200);
    chk("done32_seen", 64'(ia.done), 64'd1);
  endtask

  task automatic wait8(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ib.done && n < 200);
    chk("done8_seen", 64'(ib.done), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    ia.start = 0; ia.signed_mode = 0; ia.op_a = 0; ia.op_b = 0;
    ib.start = 0; ib.signed_mode = 0; ib.op_a = 0; ib.op_b = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(ia.busy), 0);
    chk("rst_done", 64'(ia.done), 0);
    chk("rst_hi",   64'(ia.prod_hi), 0);
    chk("rst_lo",   64'(ia.prod_lo), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 3 x -5 signed
    launch32(1'b1, 32'h3, 32'hFFFF_FFFB);
    chk("busy_run", 64'(ia.busy), 1);
    wait32(k);
    chk("lat_3x-5", 64'(k), 34);
    chk("hi_3x-5", 64'(ia.prod_hi), 64'hFFFF_FFFF);
    chk("lo_3x-5", 64'(ia.prod_lo), 64'hFFFF_FFF1);
    chk("busy_at_done", 64'(ia.busy), 0);
    @(negedge clk);
    chk("done_pulse", 64'(ia.done), 0);

    // all-ones, unsigned then signed
    launch32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait32(k);
    chk("hi_ffu", 64'(ia.prod_hi), 64'hFFFF_FFFE);
    chk("lo_ffu", 64'(ia.prod_lo), 64'h0000_0001);
    @(negedge clk);
    launch32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait32(k);
    chk("hi_ffs", 64'(ia.prod_hi), 0);
    chk("lo_ffs", 64'(ia.prod_lo), 1);

    // most negative squared, then back-to-back 7 x 6
    @(negedge clk);
    launch32(1'b1, 32'h8000_0000, 32'h8000_0000);
    wait32(k);
    chk("hi_minneg", 64'(ia.prod_hi), 64'h4000_0000);
    chk("lo_minneg", 64'(ia.prod_lo), 0);
    launch32(1'b1, 32'd7, 32'd6);
    chk("b2b_busy", 64'(ia.busy), 1);
    wait32(k);
    chk("lat_b2b", 64'(k), 34);
    chk("hi_b2b", 64'(ia.prod_hi), 0);
    chk("lo_b2b", 64'(ia.prod_lo), 42);

    // zero fast path
    @(negedge clk);
    launch32(1'b0, 32'h0, 32'h1234);
    chk("zero_busy", 64'(ia.busy), 1);
    wait32(k);
    chk("lat_zero", 64'(k), 1);
    chk("zero_busy_off", 64'(ia.busy), 0);
    chk("zero_lo", 64'(ia.prod_lo), 0);
    chk("zero_hi", 64'(ia.prod_hi), 0);

    // start during run is ignored
    @(negedge clk);
    launch32(1'b0, 32'd1000, 32'd3000);
    repeat (9) @(negedge clk);
    ia.start = 1'b1; ia.op_a = 32'd5; ia.op_b = 32'd5;
    @(negedge clk);
    ia.start = 1'b0;
    wait32(k);
    chk("lat_ign", 64'(k), 24);
    chk("hi_ign", 64'(ia.prod_hi), 0);
    chk("lo_ign", 64'(ia.prod_lo), 64'h002D_C6C0);

    // reset mid-run
    @(negedge clk);
    launch32(1'b1, 32'h1234_5678, 32'd2);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 64'(ia.busy), 0);
    chk("mrst_done", 64'(ia.done), 0);
    chk("mrst_hi", 64'(ia.prod_hi), 0);
    chk("mrst_lo", 64'(ia.prod_lo), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (50) begin
      @(negedge clk);
      if (ia.done) ndone++;
    end
    chk("mrst_nodone", 64'(ndone), 0);

    // 8-bit instance
    launch8(1'b1, 8'h80, 8'h7F);
    wait8(k);
    chk("lat8", 64'(k), 10);
    chk("hi8", 64'(ib.prod_hi), 64'hC0);
    chk("lo8", 64'(ib.prod_lo), 64'h80);
    @(negedge clk);
    launch8(1'b0, 8'hFF, 8'hFF);
    wait8(k);
    chk("hi8u", 64'(ib.prod_hi), 64'hFE);
    chk("lo8u", 64'(ib.prod_lo), 64'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/booth_mult_unit.md
# booth_mult_unit

Parametrised sequential radix-2 Booth multiplier, the successor to the fixed 32-bit datapath multiplier feeding the HI/LO registers. It adds configurable operand width, a per-operation signed/unsigned mode, a start/done pulse handshake with a busy flag, and a one-cycle fast path for zero operands. It sits beside the ALU and is driven by the control unit. Results are written to HI/LO by the control unit on `done`.

## Interface
- `WIDTH`, default 32: operand width in bits; legal range 4..64.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low. While low, all state and outputs are cleared.
- `start`  in  1: one-cycle request. Sampled only in IDLE.
- `signed_mode`  in  1: 1 = two's-complement operands, 0 = unsigned. Sampled with `start`.
- `op_a`  in  WIDTH: multiplicand. Sampled with `start`.
- `op_b`  in  WIDTH: multiplier. Sampled with `start`.
- `busy`  out  1: high whenever the state is not IDLE.
- `done`  out  1: one-cycle pulse when `prod_hi`/`prod_lo` are updated.
- `prod_hi`  out  WIDTH: upper half of the 2*WIDTH-bit product.
- `prod_lo`  out  WIDTH: lower half of the product.

## Operation
- Internal width is W1 = WIDTH+1.
  - Operands are sign-extended when `signed_mode`=1 and zero-extended otherwise. This lets one Booth datapath cover both modes.
- Accumulator layout is {A[W1-1:0], Q[W1-1:0], q_1}, 2*W1+1 bits.
  - At load: A=0, Q=extended `op_b`, q_1=0. M = extended `op_a` is held separately.
- Booth step, applied once per RUN cycle:
  - {Q[0],q_1} = 01: A += M.
  - {Q[0],q_1} = 10: A −= M.
  - 00 or 11: no add.
  - Then arithmetic right shift of the whole accumulator by one bit.
  - Add and subtract are computed modulo 2^W1.
- After W1 steps, the product is {A,Q} truncated to its low 2*WIDTH bits.
- FSM states:
  - IDLE: `start`=1 captures operands and mode. If `op_a`==0 or `op_b`==0, go to DONE with a zero product. Otherwise go to RUN with the step counter cleared.
  - RUN: perform one step per cycle and increment the counter (width clog2(W1+1)). After the step with counter = W1−1, go to DONE.
  - DONE: register `prod_hi`/`prod_lo`, pulse `done`, return to IDLE.
- Boundary and corner behaviour:
  - `start` while `busy`: ignored. No restart, no queueing. Inputs are not re-sampled.
  - `start` in the IDLE cycle immediately following `done`: accepted normally (back-to-back operation).
  - `prod_hi`/`prod_lo` hold the last result until the next DONE. They are never updated mid-operation.
  - Most-negative operands (e.g. 0x80000000 × 0x80000000): exact result required. The W1 extension guarantees no overflow.
  - Reset asserted mid-operation: immediate return to IDLE. The in-flight operation is discarded and no `done` is produced.

## Timing
- Reset values: `busy`=0, `done`=0, `prod_hi`=0, `prod_lo`=0, state=IDLE, counter=0.
- Cycle numbering: edge 0 is the edge that samples `start`.
- Normal path:
  - Steps execute at edges 1..W1.
  - Results and `done` are registered at edge W1+1.
  - For WIDTH=32, `done` is high during the cycle following edge 34.
- Zero fast path: results (0) and `done` are registered at edge 1.
- `busy` rises after edge 0. It falls at the same edge that raises `done`, so `busy`=0 while `done`=1.
- `done` is high for exactly one cycle.
- No combinational path from any input to any output.

## Structure
- Shared package `mult_pkg` contains:
  - the FSM state enum (IDLE, RUN, DONE);
  - the mode constants (MODE_UNSIGNED=0, MODE_SIGNED=1);
  - the counter-width function.
- Sub-module `booth_radix2_step`: purely combinational, parametrised by W1. It takes {A,Q,q_1} and M and returns the next accumulator. The top level holds the FSM, counter and registers.

## Test plan
- WIDTH=32, signed, 3 × −5 (0x00000003, 0xFFFFFFFB) -> `prod_hi`=0xFFFFFFFF, `prod_lo`=0xFFFFFFF1; `done` after edge 34.
- WIDTH=32, unsigned, 0xFFFFFFFF × 0xFFFFFFFF -> `prod_hi`=0xFFFFFFFE, `prod_lo`=0x00000001. Same operands signed -> `prod_hi`=0, `prod_lo`=1.
- WIDTH=32, signed, 0x80000000 × 0x80000000 -> `prod_hi`=0x40000000, `prod_lo`=0. Then a back-to-back `start` (7 × 6) in the IDLE cycle after `done` -> `prod_lo`=42.
- Zero fast path: 0 × 0x1234 -> `done` after edge 1, product 0, `busy` high for one cycle only.
- Control robustness:
  - `start` with new operands at edge 10 of a run -> ignored; the original result is produced.
  - `reset` low at edge 15 of a run -> all outputs 0, no `done`; previous `prod_hi`/`prod_lo` cleared.
- WIDTH=8 instance, signed, −128 × 127 (0x80, 0x7F) -> `prod_hi`=0xC0, `prod_lo`=0x80; `done` after edge 10.
